// File: rtl/pixel_writer.sv
// Pixel writer: buffers rasterizer pixels in a small FIFO, clips them against the
// framebuffer, and issues one req/ack write per surviving pixel.
module pixel_writer #(
   parameter int FB_WIDTH   = 64,
   parameter int FB_HEIGHT  = 64,
   parameter int COORD_W    = 7,
   parameter int COLOR_W    = 8,
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic               pix_last,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_wdata,
   input  logic               mem_ack,
   output logic               busy,
   output logic               done,
   output logic [15:0]        clip_count
);

   localparam int XW    = $clog2(FB_WIDTH);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [COORD_W-1:0] FBW_C   = COORD_W'(FB_WIDTH);
   localparam logic [COORD_W-1:0] FBH_C   = COORD_W'(FB_HEIGHT);
   localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   // Row-major linear address; FB_WIDTH is a power of two so the multiply is a shift.
   function automatic logic [ADDR_W-1:0] f_lin_addr(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y
   );
      f_lin_addr = (ADDR_W'(y) << XW) + ADDR_W'(x);
   endfunction

   logic [COORD_W-1:0] r_fifo_x     [FIFO_DEPTH];
   logic [COORD_W-1:0] r_fifo_y     [FIFO_DEPTH];
   logic [COLOR_W-1:0] r_fifo_color [FIFO_DEPTH];
   logic               r_fifo_last  [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_mem_req;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [COLOR_W-1:0] r_mem_wdata;
   logic               r_mem_last;
   logic               r_done;
   logic [15:0]        r_clip_count;

   logic               w_push;
   logic               w_pop;
   logic               w_load;
   logic               w_clip;
   logic               w_done_nxt;
   logic               w_nonempty;
   logic               w_head_inb;
   logic [COORD_W-1:0] w_head_x;
   logic [COORD_W-1:0] w_head_y;
   logic [COLOR_W-1:0] w_head_color;
   logic               w_head_last;
   logic [ADDR_W-1:0]  w_head_addr;

   assign pix_ready    = (r_count < DEPTH_C);
   assign w_push       = pix_valid & pix_ready;
   assign w_nonempty   = (r_count != '0);
   assign w_head_x     = r_fifo_x[r_rd_ptr];
   assign w_head_y     = r_fifo_y[r_rd_ptr];
   assign w_head_color = r_fifo_color[r_rd_ptr];
   assign w_head_last  = r_fifo_last[r_rd_ptr];
   assign w_head_inb   = (w_head_x < FBW_C) && (w_head_y < FBH_C);
   assign w_head_addr  = f_lin_addr(w_head_x, w_head_y);

   // FIFO payload storage; contents are only meaningful below r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_x[r_wr_ptr]     <= pix_x;
         r_fifo_y[r_wr_ptr]     <= pix_y;
         r_fifo_color[r_wr_ptr] <= pix_color;
         r_fifo_last[r_wr_ptr]  <= pix_last;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Next-state and datapath control.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_clip      = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_nonempty) begin
               w_pop = 1'b1;
               if (w_head_inb) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_WRITE;
               end else begin
                  w_clip     = 1'b1;
                  w_done_nxt = w_head_last;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WRITE: begin
            if (mem_ack) begin
               w_done_nxt = r_mem_last;
               // Out-of-bounds heads are left for IDLE so a clip never stalls a write.
               if (w_nonempty && w_head_inb) begin
                  w_pop       = 1'b1;
                  w_load      = 1'b1;
                  w_state_nxt = S_WRITE;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_state_nxt = S_WRITE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Memory request registers; held stable while waiting for ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_last  <= 1'b0;
      end else begin
         r_mem_req <= (w_state_nxt == S_WRITE);
         if (w_load) begin
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_color;
            r_mem_last  <= w_head_last;
         end
      end
   end

   // Done pulse and saturating clip counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done       <= 1'b0;
         r_clip_count <= 16'h0000;
      end else begin
         r_done <= w_done_nxt;
         if (w_clip && (r_clip_count != 16'hFFFF))
            r_clip_count <= r_clip_count + 16'h0001;
      end
   end

   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign done       = r_done;
   assign clip_count = r_clip_count;
   assign busy       = w_nonempty | r_mem_req;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: single write, streaming, backpressure,
// clipping and mid-transaction reset.
module tb_pixel_writer;

   logic        clk;
   logic        rst;
   logic        pix_valid;
   logic        pix_ready;
   logic [6:0]  pix_x;
   logic [6:0]  pix_y;
   logic [7:0]  pix_color;
   logic        pix_last;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic [15:0] clip_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int req_cnt  = 0;
   logic [11:0] q_addr[$];
   logic [7:0]  q_data[$];
   int          q_cyc[$];

   pixel_writer dut (
      .clk(clk), .rst(rst),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_last(pix_last),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .busy(busy), .done(done), .clip_count(clip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mid-cycle observer: a write completes at the next rising edge when req&ack hold now.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_req) req_cnt = req_cnt + 1;
      if (mem_req && mem_ack) begin
         q_addr.push_back(mem_addr);
         q_data.push_back(mem_wdata);
         q_cyc.push_back(cyc);
      end
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] x, input logic [6:0] y,
                        input logic [7:0] c, input logic l);
      pix_valid = v;
      pix_x     = x;
      pix_y     = y;
      pix_color = c;
      pix_last  = l;
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
      done_cnt = 0;
      req_cnt  = 0;
   endtask

   initial begin
      int idx;
      logic rdy;
      rst = 1'b1;
      mem_ack = 1'b0;
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      step();
      step();
      chk("rst_req",   32'(mem_req), 32'd0);
      chk("rst_addr",  32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_ready", 32'(pix_ready), 32'd1);
      chk("rst_clip",  32'(clip_count), 32'd0);
      rst = 1'b0;
      step();

      // Single pixel (3,5) -> 5*64+3 = 323
      clear_log();
      drive(1'b1, 7'd3, 7'd5, 8'hA5, 1'b1);
      step();
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      chk("single_req_e0", 32'(mem_req), 32'd0);
      chk("single_busy_e0", 32'(busy), 32'd1);
      step();
      chk("single_req", 32'(mem_req), 32'd1);
      chk("single_addr", 32'(mem_addr), 32'd323);
      chk("single_wdata", 32'(mem_wdata), 32'hA5);
      step();
      chk("single_hold_req", 32'(mem_req), 32'd1);
      chk("single_hold_addr", 32'(mem_addr), 32'd323);
      chk("single_no_done", 32'(done), 32'd0);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("single_req_off", 32'(mem_req), 32'd0);
      chk("single_done", 32'(done), 32'd1);
      chk("single_busy_off", 32'(busy), 32'd0);
      step();
      chk("single_done_pulse", 32'(done), 32'd0);
      chk("single_writes", 32'(q_addr.size()), 32'd1);

      // Streaming: 8 pixels on row 2 -> addresses 128..135
      clear_log();
      mem_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 7'(i), 7'd2, 8'(8'h10 + i), (i == 7));
         chk("stream_ready", 32'(pix_ready), 32'd1);
         step();
      end
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("stream_writes", 32'(q_addr.size()), 32'd8);
      if (q_addr.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("stream_addr", 32'(q_addr[i]), 32'(128 + i));
            chk("stream_data", 32'(q_data[i]), 32'(8'h10 + i));
            chk("stream_cycle", 32'(q_cyc[i]), 32'(q_cyc[0] + i));
         end
      end
      chk("stream_done_cnt", 32'(done_cnt), 32'd1);
      chk("stream_req_cnt", 32'(req_cnt), 32'd8);
      mem_ack = 1'b0;

      // Backpressure: 5 accepted with ack low, then one more after a single ack
      clear_log();
      idx = 0;
      drive(1'b1, 7'(idx), 7'd3, 8'(8'h30 + idx), 1'b0);
      for (int i = 0; i < 8; i++) begin
         rdy = pix_ready;
         step();
         if (rdy) idx++;
         drive(1'b1, 7'(idx), 7'd3, 8'(8'h30 + idx), 1'b0);
      end
      chk("bp_accepted", 32'(idx), 32'd5);
      chk("bp_ready_low", 32'(pix_ready), 32'd0);
      chk("bp_head_addr", 32'(mem_addr), 32'd192);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("bp_ready_reopen", 32'(pix_ready), 32'd1);
      chk("bp_next_addr", 32'(mem_addr), 32'd193);
      step();
      idx++;
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      chk("bp_ready_full", 32'(pix_ready), 32'd0);
      mem_ack = 1'b1;
      for (int i = 0; i < 8; i++) step();
      mem_ack = 1'b0;
      chk("bp_writes", 32'(q_addr.size()), 32'(idx));
      if (q_addr.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("bp_order_addr", 32'(q_addr[i]), 32'(192 + i));
            chk("bp_order_data", 32'(q_data[i]), 32'(8'h30 + i));
         end
      end
      chk("bp_busy_end", 32'(busy), 32'd0);
      chk("bp_no_done", 32'(done_cnt), 32'd0);

      // Clipping
      clear_log();
      mem_ack = 1'b1;
      drive(1'b1, 7'd70, 7'd1, 8'h01, 1'b0);
      step();
      drive(1'b1, 7'd2, 7'd64, 8'h02, 1'b0);
      step();
      drive(1'b1, 7'd1, 7'd1, 8'h03, 1'b1);
      step();
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("clip_count2", 32'(clip_count), 32'd2);
      chk("clip_writes", 32'(q_addr.size()), 32'd1);
      if (q_addr.size() == 1) chk("clip_addr", 32'(q_addr[0]), 32'd65);
      chk("clip_done", 32'(done_cnt), 32'd1);
      clear_log();
      drive(1'b1, 7'd100, 7'd0, 8'h04, 1'b1);
      step();
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("clip_alone_req", 32'(req_cnt), 32'd0);
      chk("clip_alone_done", 32'(done_cnt), 32'd1);
      chk("clip_count3", 32'(clip_count), 32'd3);
      mem_ack = 1'b0;

      // Reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 7'(4 + i), 7'd7, 8'(8'h70 + i), 1'b0);
         step();
      end
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      chk("mid_req_high", 32'(mem_req), 32'd1);
      chk("mid_addr", 32'(mem_addr), 32'd452);
      clear_log();
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_ack = 1'b1;
      chk("mid_rst_req", 32'(mem_req), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_clip", 32'(clip_count), 32'd0);
      chk("mid_rst_ready", 32'(pix_ready), 32'd1);
      step();
      chk("mid_no_stale_write", 32'(q_addr.size()), 32'd0);
      drive(1'b1, 7'd0, 7'd0, 8'h5A, 1'b1);
      step();
      drive(1'b0, 7'd0, 7'd0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("post_rst_writes", 32'(q_addr.size()), 32'd1);
      if (q_addr.size() == 1) begin
         chk("post_rst_addr", 32'(q_addr[0]), 32'd0);
         chk("post_rst_data", 32'(q_data[0]), 32'h5A);
      end
      chk("post_rst_done", 32'(done_cnt), 32'd1);
      mem_ack = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
